// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath main control FSM with ALU decoder
module multicycle_control #(
    parameter int OP_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ImmSrc,
    output logic            RegWrite,
    output logic [2:0]      ALUControl,
    output logic [3:0]      state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    state_t      state_q, state_d;
    logic [1:0]  alu_op;
    logic        pc_update;
    logic        branch;
    logic        ir_write_raw;
    logic        mem_write_raw;
    logic        reg_write_raw;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore next-state and per-state control outputs
    always_comb begin
        state_d       = state_q;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_R) begin
                    state_d = S_EXECUTER;
                end else if (op == OP_I) begin
                    state_d = S_EXECUTEI;
                end else if (op == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (op == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder; subtract only for R-type with funct7b5 set
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Enables are gated by rst_n so nothing is written while reset is low
    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write_raw;
    assign MemWrite = rst_n & mem_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0000000;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.OP_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb, imm;
        logic [2:0] alu;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cycles;
        int         exec_state;
        logic [2:0] exec_alu;
        logic       exec_pcw;
        logic [1:0] imm;
        int         nreg;
        int         nmem;
    } vec_t;

    typedef int iq_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference outputs for a state, written straight from the per-state control table
    function automatic outs_t ref_outs(input int st, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z, input logic mr);
        outs_t r;
        logic [1:0] aop = 2'b00;
        logic pcu = 1'b0;
        logic br = 1'b0;
        r = '{default: '0};
        case (st)
            0:  begin r.srcb = 2'b10; r.res = 2'b10; r.irw = mr; pcu = mr; end
            1:  begin r.srca = 2'b01; r.srcb = 2'b01; end
            2:  begin r.srca = 2'b10; r.srcb = 2'b01; end
            3:  begin r.adr = 1'b1; end
            4:  begin r.res = 2'b01; r.regw = 1'b1; end
            5:  begin r.adr = 1'b1; r.memw = 1'b1; end
            6:  begin r.srca = 2'b10; aop = 2'b10; end
            7:  begin r.srca = 2'b10; r.srcb = 2'b01; aop = 2'b10; end
            8:  begin r.regw = 1'b1; end
            9:  begin r.srca = 2'b10; aop = 2'b01; br = 1'b1; end
            10: begin r.srca = 2'b01; r.srcb = 2'b10; pcu = 1'b1; end
            default: ;
        endcase
        r.pcw = pcu | (br & z);
        if (aop == 2'b01) r.alu = 3'd1;
        else if (aop == 2'b10) begin
            if (f3 == 3'd0)      r.alu = (o[5] && f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) r.alu = 3'd4;
            else if (f3 == 3'd6) r.alu = 3'd3;
            else if (f3 == 3'd7) r.alu = 3'd2;
        end
        if (o == 7'b0100011)      r.imm = 2'b01;
        else if (o == 7'b1100011) r.imm = 2'b10;
        else if (o == 7'b1101111) r.imm = 2'b11;
        return r;
    endfunction

    // States visited after FETCH for one instruction (mem_ready high)
    function automatic iq_t build_path(input logic [6:0] o);
        case (o)
            7'b0000011: return '{1, 2, 3, 4};
            7'b0100011: return '{1, 2, 5};
            7'b0110011: return '{1, 6, 8};
            7'b0010011: return '{1, 7, 8};
            7'b1100011: return '{1, 9};
            7'b1101111: return '{1, 10, 8};
            default:    return '{1};
        endcase
    endfunction

    int exp_state = 0;
    int path[$];

    task automatic model_step();
        if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !mem_ready) return;
        if (exp_state == 0) path = build_path(op);
        if (path.size() == 0) exp_state = 0;
        else exp_state = path.pop_front();
    endtask

    task automatic check_all(input string tag);
        outs_t e;
        e = ref_outs(exp_state, op, funct3, funct7b5, zero, mem_ready);
        check({tag, ".state_o"}, 32'(state_o), 32'(exp_state));
        check({tag, ".PCWrite"}, 32'(PCWrite), 32'(e.pcw));
        check({tag, ".AdrSrc"}, 32'(AdrSrc), 32'(e.adr));
        check({tag, ".MemWrite"}, 32'(MemWrite), 32'(e.memw));
        check({tag, ".IRWrite"}, 32'(IRWrite), 32'(e.irw));
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(e.regw));
        check({tag, ".ResultSrc"}, 32'(ResultSrc), 32'(e.res));
        check({tag, ".ALUSrcA"}, 32'(ALUSrcA), 32'(e.srca));
        check({tag, ".ALUSrcB"}, 32'(ALUSrcB), 32'(e.srcb));
        check({tag, ".ImmSrc"}, 32'(ImmSrc), 32'(e.imm));
        check({tag, ".ALUControl"}, 32'(ALUControl), 32'(e.alu));
    endtask

    // Apply a fixed per-cycle state/mem_ready script starting in FETCH at a negedge
    task automatic run_seq(input string tag, input logic [6:0] o, input int st[$], input int mr[$]);
        op = o;
        for (int k = 0; k < st.size(); k++) begin
            mem_ready = mr[k][0];
            exp_state = st[k];
            #1;
            check_all(tag);
            if (k != st.size() - 1) @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k = 0;
        int nreg = 0;
        int nmem = 0;
        string tag;
        tag = $sformatf("vec%0d", idx);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z; mem_ready = 1'b1;
        do begin
            #1;
            if (k == 0) check({tag, ".ImmSrc"}, 32'(ImmSrc), 32'(v.imm));
            if (k == 1) check({tag, ".decode"}, 32'(state_o), 32'd1);
            if (k == 2 && v.exec_state >= 0) begin
                check({tag, ".exec_state"}, 32'(state_o), 32'(v.exec_state));
                check({tag, ".exec_alu"}, 32'(ALUControl), 32'(v.exec_alu));
                check({tag, ".exec_pcw"}, 32'(PCWrite), 32'(v.exec_pcw));
            end
            if (RegWrite) nreg++;
            if (MemWrite) nmem++;
            @(negedge clk);
            k++;
        end while (state_o != 4'd0 && k < 12);
        check({tag, ".cycles"}, 32'(k), 32'(v.cycles));
        check({tag, ".nreg"}, 32'(nreg), 32'(v.nreg));
        check({tag, ".nmem"}, 32'(nmem), 32'(v.nmem));
    endtask

    vec_t vecs[$];
    logic [6:0] ops[8];

    initial begin
        // op, f3, f7, z, cycles, exec_state, exec_alu, exec_pcw, imm, nreg, nmem
        vecs.push_back('{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 6, 3'd0, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 6, 3'd1, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 6, 3'd4, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0110011, 3'd1, 1'b1, 1'b1, 4, 6, 3'd0, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 7, 3'd0, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0010011, 3'd2, 1'b0, 1'b0, 4, 7, 3'd4, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0010011, 3'd7, 1'b0, 1'b0, 4, 7, 3'd2, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0010011, 3'd6, 1'b0, 1'b0, 4, 7, 3'd3, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 2, 3'd0, 1'b0, 2'd0, 1, 0});
        vecs.push_back('{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 2, 3'd0, 1'b0, 2'd1, 0, 1});
        vecs.push_back('{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 9, 3'd1, 1'b1, 2'd2, 0, 0});
        vecs.push_back('{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 9, 3'd1, 1'b0, 2'd2, 0, 0});
        vecs.push_back('{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 10, 3'd0, 1'b1, 2'd3, 1, 0});
        vecs.push_back('{7'b0000000, 3'd0, 1'b0, 1'b0, 2, -1, 3'd0, 1'b0, 2'd0, 0, 0});
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0000000, 7'b1111111};

        // Reset held for three cycles: FETCH with every enable low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst.state_o", 32'(state_o), 32'd0);
            check("rst.PCWrite", 32'(PCWrite), 32'd0);
            check("rst.IRWrite", 32'(IRWrite), 32'd0);
            check("rst.MemWrite", 32'(MemWrite), 32'd0);
            check("rst.RegWrite", 32'(RegWrite), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel.IRWrite", 32'(IRWrite), 32'd1);
        check("rel.PCWrite", 32'(PCWrite), 32'd1);
        check("rel.ALUControl", 32'(ALUControl), 32'd0);
        @(negedge clk);
        check("rel.decode", 32'(state_o), 32'd1);
        @(negedge clk);
        check("rel.back", 32'(state_o), 32'd0);

        // Table-driven instruction vectors
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // lw with two stall cycles in MEMREAD: 7 cycles total
        funct3 = 3'd2;
        run_seq("lwstall", 7'b0000011, '{0, 1, 2, 3, 3, 3, 4}, '{1, 1, 1, 0, 0, 1, 1});
        @(negedge clk);
        #1;
        check("lwstall.end", 32'(state_o), 32'd0);

        // Stall in FETCH then an unknown op
        run_seq("fstall", 7'b0000000, '{0, 0, 1}, '{0, 1, 1});
        @(negedge clk);
        #1;
        check("fstall.end", 32'(state_o), 32'd0);

        // sw stalled in MEMWRITE, then reset pulse mid-write
        run_seq("swrst", 7'b0100011, '{0, 1, 2, 5, 5}, '{1, 1, 1, 0, 0});
        rst_n = 1'b0;
        #1;
        check("swrst.MemWrite", 32'(MemWrite), 32'd0);
        check("swrst.state_o", 32'(state_o), 32'd0);
        check("swrst.IRWrite", 32'(IRWrite), 32'd0);
        check("swrst.PCWrite", 32'(PCWrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        op = 7'b0000000;
        #1;
        check("swrst.refetch", 32'(IRWrite), 32'd1);
        @(negedge clk);
        check("swrst.decode", 32'(state_o), 32'd1);
        @(negedge clk);
        exp_state = 0;
        path.delete();

        // Randomized run against the instruction-level model
        for (int c = 0; c < 600; c++) begin
            if (exp_state == 0) begin
                op = ops[$urandom_range(0, 7)];
                funct3 = 3'($urandom_range(0, 7));
                funct7b5 = 1'($urandom_range(0, 1));
            end
            zero = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 7);
            #1;
            check_all("rand");
            model_step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
